// File: rtl/pic_bus_initiator.sv
// CPU-side bus master for the 8259A PIC: runs the ICW1..ICW4 init sequence,
// then single OCW writes / status reads through a valid/ready command port.
module pic_bus_initiator #(
  parameter int unsigned SETUP_CYCLES = 1,
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_start,
  input  logic [7:0] icw1,
  input  logic [7:0] icw2,
  input  logic [7:0] icw3,
  input  logic [7:0] icw4,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_read,
  input  logic       cmd_a0,
  input  logic [7:0] cmd_data,
  output logic [7:0] rd_data,
  output logic       rd_data_valid,
  output logic       busy,
  output logic       init_done,
  output logic       chip_select_bar,
  output logic       read_bar,
  output logic       write_bar,
  output logic       A0,
  output logic [7:0] data_bus_out,
  output logic       data_bus_oe,
  input  logic [7:0] data_bus_in
);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;

  localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYCLES - 1);
  localparam logic [3:0] HOLD_LAST  = 4'(HOLD_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d;
  logic       seq_q, seq_d, done_q, done_d, rd_q, rd_d, a0_q, a0_d, rdv_q, rdv_d;
  logic [7:0] data_q, data_d, rdat_q, rdat_d;
  logic [7:0] icw1_q, icw1_d, icw2_q, icw2_d, icw3_q, icw3_d, icw4_q, icw4_d;
  logic [1:0] next_idx;
  logic       last_icw;
  logic [7:0] icw_sel;

  // Which ICW follows the current one; ICW1 bit1 = single (no ICW3), bit0 = ICW4 needed.
  always_comb begin
    last_icw = 1'b0;
    next_idx = 2'd1;
    icw_sel  = icw1_q;
    case (idx_q)
      2'd0: next_idx = 2'd1;
      2'd1: begin
        if (!icw1_q[1])     next_idx = 2'd2;
        else if (icw1_q[0]) next_idx = 2'd3;
        else                last_icw = 1'b1;
      end
      2'd2: begin
        if (icw1_q[0]) next_idx = 2'd3;
        else           last_icw = 1'b1;
      end
      default: last_icw = 1'b1;
    endcase
    case (idx_q)
      2'd0:    icw_sel = icw1_q;
      2'd1:    icw_sel = icw2_q;
      2'd2:    icw_sel = icw3_q;
      default: icw_sel = icw4_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    seq_d   = seq_q;
    done_d  = done_q;
    rd_d    = rd_q;
    a0_d    = a0_q;
    data_d  = data_q;
    rdat_d  = rdat_q;
    rdv_d   = 1'b0;
    icw1_d  = icw1_q;
    icw2_d  = icw2_q;
    icw3_d  = icw3_q;
    icw4_d  = icw4_q;
    busy      = (state_q != IDLE) | seq_q;
    cmd_ready = (state_q == IDLE) & done_q & ~init_start;
    case (state_q)
      IDLE: begin
        if (seq_q) begin
          state_d = SETUP;
          cnt_d   = 4'd0;
          rd_d    = 1'b0;
          a0_d    = 1'b1;
          data_d  = icw_sel;
        end else if (init_start) begin
          icw1_d  = icw1 | 8'h10;
          icw2_d  = icw2 & 8'hF8;
          icw3_d  = icw3;
          icw4_d  = icw4 & 8'h13;
          seq_d   = 1'b1;
          idx_d   = 2'd0;
          done_d  = 1'b0;
          state_d = SETUP;
          cnt_d   = 4'd0;
          rd_d    = 1'b0;
          a0_d    = 1'b0;
          data_d  = icw1 | 8'h10;
        end else if (cmd_valid && cmd_ready) begin
          state_d = SETUP;
          cnt_d   = 4'd0;
          rd_d    = cmd_read;
          a0_d    = cmd_a0;
          data_d  = cmd_data;
        end
      end
      SETUP: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SETUP_LAST) begin
          state_d = STROBE;
          cnt_d   = 4'd0;
        end
      end
      STROBE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == PULSE_LAST) begin
          state_d = HOLD;
          cnt_d   = 4'd0;
          if (rd_q) rdat_d = data_bus_in;
        end
      end
      default: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == HOLD_LAST) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          rdv_d   = rd_q;
          if (seq_q) begin
            if (last_icw) begin
              seq_d  = 1'b0;
              done_d = 1'b1;
            end else begin
              idx_d  = next_idx;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= 2'd0;
      seq_q   <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      a0_q    <= 1'b0;
      rdv_q   <= 1'b0;
      data_q  <= 8'h00;
      rdat_q  <= 8'h00;
      icw1_q  <= 8'h00;
      icw2_q  <= 8'h00;
      icw3_q  <= 8'h00;
      icw4_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      seq_q   <= seq_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
      a0_q    <= a0_d;
      rdv_q   <= rdv_d;
      data_q  <= data_d;
      rdat_q  <= rdat_d;
      icw1_q  <= icw1_d;
      icw2_q  <= icw2_d;
      icw3_q  <= icw3_d;
      icw4_q  <= icw4_d;
    end
  end

  assign chip_select_bar = (state_q == IDLE);
  assign write_bar       = ~((state_q == STROBE) & ~rd_q);
  assign read_bar        = ~((state_q == STROBE) & rd_q);
  assign A0              = a0_q;
  assign data_bus_out    = data_q;
  assign data_bus_oe     = (state_q != IDLE) & ~rd_q;
  assign rd_data         = rdat_q;
  assign rd_data_valid   = rdv_q;
  assign init_done       = done_q;
endmodule

// File: tb/tb_pic_bus_initiator.sv
// Scoreboard bench: stimulus pushes expected bus accesses / read data,
// a negedge bus monitor reconstructs each access and compares.
module tb_pic_bus_initiator;
  logic       clk = 1'b0, reset = 1'b1, init_start = 1'b0;
  logic [7:0] icw1 = 8'h00, icw2 = 8'h00, icw3 = 8'h00, icw4 = 8'h00;
  logic       cmd_valid = 1'b0, cmd_read = 1'b0, cmd_a0 = 1'b0;
  logic [7:0] cmd_data = 8'h00, data_bus_in = 8'h5A;
  logic       cmd_ready, rd_data_valid, busy, init_done;
  logic       chip_select_bar, read_bar, write_bar, A0, data_bus_oe;
  logic [7:0] rd_data, data_bus_out;

  pic_bus_initiator dut (
    .clk(clk), .reset(reset), .init_start(init_start),
    .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
    .cmd_a0(cmd_a0), .cmd_data(cmd_data), .rd_data(rd_data),
    .rd_data_valid(rd_data_valid), .busy(busy), .init_done(init_done),
    .chip_select_bar(chip_select_bar), .read_bar(read_bar), .write_bar(write_bar),
    .A0(A0), .data_bus_out(data_bus_out), .data_bus_oe(data_bus_oe),
    .data_bus_in(data_bus_in)
  );

  always #5 clk = ~clk;

  typedef struct {bit rd; bit a0; bit [7:0] d; bit abort;} acc_t;
  acc_t     exp_q[$];
  bit [7:0] rdx_q[$];
  int       n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_acc(input bit rd, input bit a0, input bit [7:0] d, input bit abort);
    acc_t e;
    e.rd = rd; e.a0 = a0; e.d = d; e.abort = abort;
    exp_q.push_back(e);
  endtask

  task automatic start_init(input bit [7:0] i1, i2, i3, i4);
    icw1 = i1; icw2 = i2; icw3 = i3; icw4 = i4;
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; busy && n < 200; n++) tick();
    if (busy) chk("wait_idle_timeout", 1, 0);
  endtask

  task automatic send_cmd(input bit rd, input bit a0, input bit [7:0] d);
    int n;
    cmd_valid = 1'b1; cmd_read = rd; cmd_a0 = a0; cmd_data = d;
    for (n = 0; !cmd_ready && n < 50; n++) tick();
    if (!cmd_ready) chk("cmd_ready_timeout", 1, 0);
    tick();
    cmd_valid = 1'b0;
    chk("cmd_ready_in_access", cmd_ready, 0);
    wait_idle();
  endtask

  // Bus monitor: one access spans a contiguous run of CS-low cycles.
  bit       in_acc = 0, a0_first, a0_bad, oe_all, oe_any, prev_rdv = 0;
  int       cs_cnt, wr_cnt, rd_cnt;
  bit [7:0] wr_data;
  always @(negedge clk) begin
    if (!chip_select_bar) begin
      if (!in_acc) begin
        in_acc = 1; cs_cnt = 0; wr_cnt = 0; rd_cnt = 0;
        a0_first = A0; a0_bad = 0; oe_all = 1; oe_any = 0; wr_data = 8'h00;
      end
      cs_cnt++;
      if (!write_bar) begin wr_cnt++; wr_data = data_bus_out; end
      if (!read_bar) rd_cnt++;
      if (!read_bar && !write_bar) chk("rd_wr_both_low", 1, 0);
      if (A0 != a0_first) a0_bad = 1;
      oe_all &= data_bus_oe;
      oe_any |= data_bus_oe;
    end else if (in_acc) begin
      in_acc = 0;
      if (exp_q.size() == 0) chk("unexpected_access", 1, 0);
      else begin
        acc_t e;
        e = exp_q.pop_front();
        chk("acc_is_read", int'(rd_cnt > 0), int'(e.rd));
        chk("acc_a0", a0_first, e.a0);
        if (!e.rd) chk("acc_wdata", wr_data, e.d);
        if (!e.abort) begin
          chk("acc_cs_len", cs_cnt, 4);
          chk("acc_strobe_len", e.rd ? rd_cnt : wr_cnt, 2);
          chk("acc_a0_stable", a0_bad, 0);
          if (e.rd) chk("acc_read_oe", oe_any, 0);
          else      chk("acc_write_oe", oe_all, 1);
        end
      end
    end
    if (rd_data_valid) begin
      if (rdx_q.size() == 0) chk("unexpected_rd_valid", 1, 0);
      else chk("rd_data", rd_data, rdx_q.pop_front());
      chk("rdv_single_pulse", prev_rdv, 0);
    end
    prev_rdv = rd_data_valid;
  end

  initial begin
    tick(); tick();
    reset = 1'b0;
    chk("rst_cs", chip_select_bar, 1); chk("rst_rd", read_bar, 1);
    chk("rst_wr", write_bar, 1);       chk("rst_a0", A0, 0);
    chk("rst_dbo", data_bus_out, 0);   chk("rst_oe", data_bus_oe, 0);
    chk("rst_ready", cmd_ready, 0);    chk("rst_busy", busy, 0);
    chk("rst_done", init_done, 0);     chk("rst_rdata", rd_data, 0);
    chk("rst_rdv", rd_data_valid, 0);

    // Command held before init: must wait for the full ICW sequence.
    cmd_valid = 1'b1; cmd_read = 1'b0; cmd_a0 = 1'b1; cmd_data = 8'hFE;
    repeat (5) tick();
    chk("pre_init_ready", cmd_ready, 0);
    chk("pre_init_busy", busy, 0);
    push_acc(0, 0, 8'h11, 0); push_acc(0, 1, 8'h20, 0);
    push_acc(0, 1, 8'h04, 0); push_acc(0, 1, 8'h01, 0);
    push_acc(0, 1, 8'hFE, 0);
    start_init(8'h11, 8'h20, 8'h04, 8'h01);
    repeat (18) tick();
    chk("full_done_early", init_done, 0);
    chk("full_busy_last_hold", busy, 1);
    tick();
    chk("full_done_at_20", init_done, 1);
    chk("full_busy_end", busy, 0);
    chk("full_ready_after", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    chk("ocw1_ready_low", cmd_ready, 0);
    chk("ocw1_busy", busy, 1);
    wait_idle();
    chk("gap_cs_high", chip_select_bar, 1);

    // OCW3 then status read.
    push_acc(0, 0, 8'h0A, 0);
    send_cmd(0, 0, 8'h0A);
    push_acc(1, 0, 8'h00, 0);
    rdx_q.push_back(8'h5A);
    send_cmd(1, 0, 8'h00);
    chk("rdv_at_first_idle", rd_data_valid, 1);
    tick();
    chk("rdv_dropped", rd_data_valid, 0);

    // Skip ICW3, mask ICW2 low bits.
    push_acc(0, 0, 8'h13, 0); push_acc(0, 1, 8'h20, 0); push_acc(0, 1, 8'h01, 0);
    start_init(8'h13, 8'h27, 8'h55, 8'h01);
    chk("skip_done_cleared", init_done, 0);
    repeat (13) tick();
    chk("skip_done_early", init_done, 0);
    tick();
    chk("skip_done_at_15", init_done, 1);

    // Two-ICW init; a second init_start while busy is ignored.
    push_acc(0, 0, 8'h12, 0); push_acc(0, 1, 8'h40, 0);
    start_init(8'h12, 8'h40, 8'h00, 8'h00);
    tick(); tick();
    icw1 = 8'h11; icw2 = 8'h88; icw3 = 8'h04; icw4 = 8'h01;
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    wait_idle();
    chk("two_icw_done", init_done, 1);
    tick(); tick();

    // Reset during ICW2 strobe abandons the sequence.
    push_acc(0, 0, 8'h11, 0); push_acc(0, 1, 8'h20, 1);
    start_init(8'h11, 8'h20, 8'h04, 8'h01);
    repeat (6) tick();
    chk("icw2_strobe_low", write_bar, 0);
    reset = 1'b1;
    tick();
    chk("mid_rst_cs", chip_select_bar, 1); chk("mid_rst_wr", write_bar, 1);
    chk("mid_rst_rd", read_bar, 1);        chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", init_done, 0);
    reset = 1'b0;
    repeat (5) tick();
    chk("post_rst_idle_cs", chip_select_bar, 1);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("rd_q_empty", rdx_q.size(), 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/pic_bus_initiator.md
# pic_bus_initiator

CPU-side bus master for the 8259A PIC core: it drives `chip_select_bar`, `read_bar`, `write_bar`, `A0` and the data bus in the order and timing the PIC's read/write logic decodes. On `init_start` it issues the ICW1–ICW4 initialization sequence, skipping ICW3/ICW4 according to ICW1. After that it performs single OCW writes and status reads through a valid/ready command port. It sits between the system controller (or testbench CPU model) and the PIC top level.

## Interface
- `SETUP_CYCLES`, 1: cycles with CS/A0/data valid before the strobe goes low (range 1..15).
- `PULSE_CYCLES`, 2: cycles the `write_bar`/`read_bar` strobe is held low (range 1..15).
- `HOLD_CYCLES`, 1: cycles CS/A0/data are held after the strobe rises (range 1..15).

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `init_start` in 1: one-cycle request to run the ICW sequence.
- `icw1`, `icw2`, `icw3`, `icw4` in 8 each: ICW values, sampled on the cycle `init_start` is accepted.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake; a command transfers when both are high on a clock edge.
- `cmd_read` in 1: 1 = read access, 0 = write access.
- `cmd_a0` in 1: value driven on `A0` for the access.
- `cmd_data` in 8: write data.
- `rd_data` out 8: read result.
- `rd_data_valid` out 1: one-cycle pulse when `rd_data` is updated.
- `busy` out 1: an access or the init sequence is in progress.
- `init_done` out 1: set after the last ICW; cleared by reset or by `init_start`.
- `chip_select_bar`, `read_bar`, `write_bar` out 1 each: active-low PIC strobes.
- `A0` out 1: PIC register select.
- `data_bus_out` out 8: data driven to the PIC.
- `data_bus_oe` out 1: data-bus output enable.
- `data_bus_in` in 8: data returned from the PIC.

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD.
  - One 4-bit phase counter serves SETUP, STROBE and HOLD.
  - A 2-bit ICW index plus a sequence flag sequence the init writes.
- Acceptance, evaluated only in IDLE:
  - `init_start` has priority over `cmd_valid`.
  - `init_start` is ignored while `busy`=1.
- Init sequence:
  - ICW1 is always written, with `A0`=0 and data `icw1` with bit4 forced to 1.
  - ICW2 is always written, with `A0`=1 and data `icw2` with bits[2:0] forced to 0.
  - ICW3 is written (`A0`=1, data `icw3`) only if `icw1[1]`=0.
  - ICW4 is written (`A0`=1, data `icw4` with bits[7:5] and [3:2] forced to 0) only if `icw1[0]`=1.
  - `init_done` is 1 from the first IDLE cycle after the last ICW's HOLD.
- `cmd_ready` = (state==IDLE) & `init_done` & ~`init_start`.
- Commands are forwarded raw with no field decoding. Software must not issue ICW1 through the command port.
- Write access:
  - `data_bus_oe`=1 and `data_bus_out`=data from SETUP through HOLD.
  - `write_bar`=0 only in STROBE.
- Read access:
  - `data_bus_oe`=0 throughout; `read_bar`=0 only in STROBE.
  - `data_bus_in` is registered on the edge that ends the last STROBE cycle.
  - `rd_data_valid` pulses in the first IDLE cycle after HOLD.
- Bus signals during an access:
  - `chip_select_bar`=0 in SETUP, STROBE and HOLD.
  - `A0` is stable for the whole access.
  - `read_bar` and `write_bar` are never low together.
- Reset values: `chip_select_bar`=`read_bar`=`write_bar`=1; `A0`=0; `data_bus_out`=0x00; `data_bus_oe`=0; `cmd_ready`=0; `busy`=0; `init_done`=0; `rd_data`=0x00; `rd_data_valid`=0; state=IDLE.
- Reset mid-access: all strobes and CS go high at the next edge, the access is abandoned, `init_done` clears, and a new `init_start` is required.

## Timing
- Acceptance edge E0 → SETUP begins at E0+1.
- Access length L = `SETUP_CYCLES`+`PULSE_CYCLES`+`HOLD_CYCLES` cycles with CS low; default 4.
- After every access there is at least one IDLE cycle with CS, RD and WR high. This includes between ICWs: the next ICW starts SETUP on the edge after the IDLE gap.
- Init duration: N×(L+1) cycles, N∈{2,3,4}. `init_done` rises at cycle E0+N×(L+1).
- Read latency: `rd_data_valid` at cycle E0+L+1 relative to the acceptance edge.
- Back-to-back commands: maximum throughput is one access per L+1 cycles.
- `busy`=1 from E0+1 until the last HOLD cycle inclusive.

## Test plan
- Full init: reset, then `init_start` with icw1=0x11, icw2=0x20, icw3=0x04, icw4=0x01.
  - Expect 4 writes: A0/data = 0/0x11, 1/0x20, 1/0x04, 1/0x01.
  - Each has `write_bar` low for exactly 2 cycles and CS low for 4.
  - `init_done`=1 at start+20.
- ICW skipping:
  - icw1=0x13, icw2=0x27 → writes 0x13, 0x20, 0x01 (ICW3 skipped, bits[2:0] masked); `init_done` at +15.
  - icw1=0x12 → 2 writes only.
- OCW1 write: `cmd_a0`=1, data 0xFE → a single write.
  - `cmd_ready`=0 during the access; CS high for ≥1 cycle before the next access.
- Status read: OCW3 write (A0=0, 0x0A), then read with `data_bus_in`=0x5A.
  - `rd_data`=0x5A with `rd_data_valid` high for exactly 1 cycle.
  - `data_bus_oe`=0 throughout the read.
- Reset asserted during STROBE of ICW2: the next cycle has all strobes high, `busy`=0 and `init_done`=0.
- Commands before init: `cmd_valid` held high → no access until `init_done`.
  - `init_start` pulsed while `busy` → ignored; the sequence is unchanged.
